// File: rtl/alu_div_seq_pkg.sv
// alu_div_seq_pkg: shared definitions for the sequential divider.
//   - DIV_WIDTH     : default operand/result width (also the iteration count)
//   - ST_*          : FSM state encoding
//   - DIVZ_QUO_BIT  : fill bit of the divide-by-zero quotient (all ones)
//   - div_res_t     : packed quotient/remainder/zero-flag bundle at the default width
package alu_div_seq_pkg;

    localparam int DIV_WIDTH = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam bit DIVZ_QUO_BIT = 1'b1;

    typedef struct packed {
        logic [DIV_WIDTH-1:0] quo;
        logic [DIV_WIDTH-1:0] rem;
        logic                 divzero;
    } div_res_t;

endpackage

// File: rtl/alu_div_seq_if.sv
// alu_div_seq_if: request/result bundle between the EX stage and the divider.
//   Start/Signed/A/B      : request side (driven by master)
//   Busy/Done             : status (driven by slave)
//   Quotient/Remainder    : LO/HI results (driven by slave)
//   DivZero               : last divide had a zero divisor (driven by slave)
interface alu_div_seq_if #(
    parameter int WIDTH = alu_div_seq_pkg::DIV_WIDTH
);
    logic             Start;
    logic             Signed;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Quotient;
    logic [WIDTH-1:0] Remainder;
    logic             DivZero;

    modport master (
        output Start, Signed, A, B,
        input  Busy, Done, Quotient, Remainder, DivZero
    );

    modport slave (
        input  Start, Signed, A, B,
        output Busy, Done, Quotient, Remainder, DivZero
    );
endinterface

// File: rtl/alu_div_seq_step.sv
// div_step: one combinational restoring-division iteration.
//   rem      in  WIDTH+1 : partial remainder (always < divisor, so top bit is 0)
//   quo      in  WIDTH   : dividend bits still to shift in / quotient bits so far
//   divisor  in  WIDTH+1 : zero-extended divisor magnitude
//   rem_next out WIDTH+1 : partial remainder after this step
//   quo_next out WIDTH   : quotient register after this step
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH:0]   divisor,
    output logic [WIDTH:0]   rem_next,
    output logic [WIDTH-1:0] quo_next
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           ge;
    logic           rem_top_unused;

    // rem never reaches the divisor, so its top bit is always 0 and drops out of the shift
    assign rem_top_unused = rem[WIDTH];

    assign shifted = {rem[WIDTH-1:0], quo[WIDTH-1]};
    assign diff    = shifted - divisor;
    assign ge      = (shifted >= divisor);

    assign rem_next = ge ? diff : shifted;
    assign quo_next = {quo[WIDTH-2:0], ge};
endmodule

// File: rtl/alu_div_seq.sv
// alu_div_seq: iterative restoring divider (div/divu) for the EX stage.
//   Clk  : clock, rising edge
//   Rst  : asynchronous active-low reset
//   bus  : alu_div_seq_if.slave
//          Start/Signed/A/B in; Busy, Done, Quotient (LO), Remainder (HI), DivZero out
// One quotient bit per cycle over WIDTH RUN cycles, then one FIX cycle that applies
// sign correction and loads the output registers. All outputs are registered or
// decoded from the state register.
module alu_div_seq
    import alu_div_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic         Clk,
    input  logic         Rst,
    alu_div_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH:0]   dvsr_q;
    logic [WIDTH-1:0] quo_q;
    logic             a_neg;
    logic             q_neg;
    logic             divz;

    logic [WIDTH:0]   rem_n;
    logic [WIDTH-1:0] quo_n;

    logic             accept;
    logic             b_zero;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    assign accept = bus.Start && (state == ST_IDLE || state == ST_DONE);
    assign b_zero = (bus.B == '0);
    // -2^(WIDTH-1) negates to itself, which read unsigned is the correct magnitude
    assign mag_a  = (bus.Signed && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    assign mag_b  = (bus.Signed && bus.B[WIDTH-1]) ? -bus.B : bus.B;

    assign bus.Busy = (state == ST_RUN) || (state == ST_FIX);
    assign bus.Done = (state == ST_DONE);

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (dvsr_q),
        .rem_next (rem_n),
        .quo_next (quo_n)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            rem_q         <= '0;
            dvsr_q        <= '0;
            quo_q         <= '0;
            a_neg         <= 1'b0;
            q_neg         <= 1'b0;
            divz          <= 1'b0;
            bus.Quotient  <= '0;
            bus.Remainder <= '0;
            bus.DivZero   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        rem_q  <= '0;
                        // zero divisor keeps the raw dividend so it can be returned untouched
                        quo_q  <= b_zero ? bus.A : mag_a;
                        dvsr_q <= {1'b0, mag_b};
                        a_neg  <= bus.Signed && bus.A[WIDTH-1];
                        q_neg  <= bus.Signed && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                        divz   <= b_zero;
                        cnt    <= CW'(WIDTH);
                        state  <= b_zero ? ST_FIX : ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    rem_q <= rem_n;
                    quo_q <= quo_n;
                    cnt   <= cnt - CW'(1);
                    if (cnt == CW'(1))
                        state <= ST_FIX;
                end
                ST_FIX: begin
                    if (divz) begin
                        bus.Quotient  <= {WIDTH{DIVZ_QUO_BIT}};
                        bus.Remainder <= quo_q;
                    end else begin
                        bus.Quotient  <= q_neg ? -quo_q : quo_q;
                        bus.Remainder <= a_neg ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                    end
                    bus.DivZero <= divz;
                    state       <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_div_seq.sv
module tb_alu_div_seq;
    import alu_div_seq_pkg::*;

    localparam int W = 32;

    logic Clk = 1'b0;
    logic Rst = 1'b1;

    alu_div_seq_if #(.WIDTH(W)) bus ();

    alu_div_seq #(.WIDTH(W)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } res_t;

    // Architectural result of div/divu from plain integer arithmetic.
    function automatic res_t model_div(logic [W-1:0] a, logic [W-1:0] b, logic sg);
        res_t res;
        int   sa, sb;
        res.dz = 1'b0;
        if (b == '0) begin
            res.q  = '1;
            res.r  = a;
            res.dz = 1'b1;
        end else if (!sg) begin
            res.q = a / b;
            res.r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            res.q = 32'h8000_0000;
            res.r = '0;
        end else begin
            sa    = a;
            sb    = b;
            res.q = sa / sb;
            res.r = sa % sb;
        end
        return res;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-level model: latency and visibility of results, no state encoding.
    int   cyc      = 0;
    int   done_at  = 0;
    bit   m_active = 1'b0;
    bit   m_done   = 1'b0;
    res_t pend     = '0;
    res_t vis      = '0;

    always @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            vis      = '0;
        end else begin
            cyc++;
            m_done = 1'b0;
            if (!m_active && bus.Start) begin
                pend     = model_div(bus.A, bus.B, bus.Signed);
                m_active = 1'b1;
                done_at  = cyc + ((bus.B == '0) ? 1 : W + 1);
            end else if (m_active && cyc == done_at) begin
                m_active = 1'b0;
                m_done   = 1'b1;
                vis      = pend;
            end
        end
    end

    always @(negedge Clk) begin
        chk("busy", bus.Busy, m_active);
        chk("done", bus.Done, m_done);
        chk("quotient", bus.Quotient, vis.q);
        chk("remainder", bus.Remainder, vis.r);
        chk("divzero", bus.DivZero, vis.dz);
    end

    task automatic issue(logic [W-1:0] a, logic [W-1:0] b, logic sg);
        @(posedge Clk);
        #1;
        bus.Start  = 1'b1;
        bus.A      = a;
        bus.B      = b;
        bus.Signed = sg;
        @(posedge Clk);
        #1;
        bus.Start = 1'b0;
    endtask

    // Returns the cycle index (1 = first cycle after the sampling edge) of Done, 0 if none.
    task automatic wait_done(output int lat, output int busy_n);
        lat    = 0;
        busy_n = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge Clk);
            if (bus.Busy) busy_n++;
            if (bus.Done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic chk_res(string name, logic [W-1:0] q, logic [W-1:0] r, logic dz);
        chk({name, "_q"}, bus.Quotient, q);
        chk({name, "_r"}, bus.Remainder, r);
        chk({name, "_dz"}, bus.DivZero, dz);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   lat, busy_n, dn;
        res_t r;
        bus.Start  = 1'b0;
        bus.Signed = 1'b0;
        bus.A      = '0;
        bus.B      = '0;
        #1 Rst = 1'b0;
        repeat (3) @(negedge Clk);
        chk("rst_busy", bus.Busy, 1'b0);
        chk("rst_done", bus.Done, 1'b0);
        chk_res("rst", 32'd0, 32'd0, 1'b0);

        // pin the model with hand-computed results
        r = model_div(32'd100, 32'd7, 1'b0);
        chk("model_u", {r.q, r.r}, {32'd14, 32'd2});
        r = model_div(32'hFFFF_FFF9, 32'd2, 1'b1);
        chk("model_s", {r.q, r.r}, {32'hFFFF_FFFD, 32'hFFFF_FFFF});
        r = model_div(32'h1234_5678, 32'd0, 1'b1);
        chk("model_z", {r.q, r.r, 31'd0, r.dz}, {32'hFFFF_FFFF, 32'h1234_5678, 32'd1});

        @(negedge Clk);
        #2 Rst = 1'b1;

        // unsigned 100 / 7
        issue(32'd100, 32'd7, 1'b0);
        wait_done(lat, busy_n);
        chk("u_lat", lat, 34);
        chk("u_busy", busy_n, 33);
        chk_res("u", 32'd14, 32'd2, 1'b0);

        // signed sign rules
        issue(32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_done(lat, busy_n);
        chk("s1_lat", lat, 34);
        chk_res("s1", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        issue(32'd7, 32'hFFFF_FFFE, 1'b1);
        wait_done(lat, busy_n);
        chk_res("s2", 32'hFFFF_FFFD, 32'd1, 1'b0);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_done(lat, busy_n);
        chk_res("ovf", 32'h8000_0000, 32'd0, 1'b0);

        // divide by zero
        issue(32'h1234_5678, 32'd0, 1'b1);
        wait_done(lat, busy_n);
        chk("z_lat", lat, 2);
        chk("z_busy", busy_n, 1);
        chk_res("z", 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);

        // following divide clears DivZero, then back-to-back from its Done cycle
        issue(32'd100, 32'd7, 1'b0);
        wait_done(lat, busy_n);
        chk_res("clr", 32'd14, 32'd2, 1'b0);
        bus.Start  = 1'b1;
        bus.A      = 32'hFFFF_FFFF;
        bus.B      = 32'd1;
        bus.Signed = 1'b0;
        @(posedge Clk);
        #1 bus.Start = 1'b0;
        chk("b2b_busy", bus.Busy, 1'b1);
        repeat (10) @(negedge Clk);
        chk_res("b2b_hold", 32'd14, 32'd2, 1'b0);
        wait_done(lat, busy_n);
        chk("b2b_lat", lat + 10, 34);
        chk_res("b2b", 32'hFFFF_FFFF, 32'd0, 1'b0);

        // Start while busy is ignored
        issue(32'd1000, 32'd10, 1'b0);
        repeat (9) @(negedge Clk);
        bus.Start = 1'b1;
        bus.A     = 32'd5;
        bus.B     = 32'd5;
        @(posedge Clk);
        #1 bus.Start = 1'b0;
        wait_done(lat, busy_n);
        chk("busy_lat", lat + 9, 34);
        chk_res("busy", 32'd100, 32'd0, 1'b0);
        dn = 0;
        repeat (40) begin
            @(negedge Clk);
            if (bus.Done) dn++;
        end
        chk("busy_extra_done", dn, 0);

        // reset mid-operation
        issue(32'd100, 32'd7, 1'b0);
        repeat (14) @(negedge Clk);
        #2 Rst = 1'b0;
        #1;
        chk("mrst_busy", bus.Busy, 1'b0);
        chk("mrst_done", bus.Done, 1'b0);
        chk_res("mrst", 32'd0, 32'd0, 1'b0);
        dn = 0;
        repeat (40) begin
            @(negedge Clk);
            if (bus.Done) dn++;
        end
        chk("mrst_no_done", dn, 0);
        #2 Rst = 1'b1;
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_done(lat, busy_n);
        chk("post_lat", lat, 34);
        chk_res("post", 32'd0, 32'h8000_0000, 1'b0);

        repeat (3) @(negedge Clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
